// File: rtl/cache_req_arb_pkg.sv
// Shared types and constants for the cache request arbiter family.
package cache_arb_pkg;

  localparam int DEF_NUM_REQ        = 2;
  localparam int DEF_MAX_LOCK_BEATS = 8;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int src_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cache_req_arb_if.sv
// Request-side and downstream-side handshake bundle of cache_req_arb.
interface cache_req_arb_if
  import cache_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = 5
);
  localparam int SRC_W = src_idx_w(NUM_REQ);

  logic [NUM_REQ-1:0]            i_valid;
  logic [NUM_REQ-1:0]            o_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0] i_data;
  logic [NUM_REQ-1:0]            i_lock;
  logic                          o_valid;
  logic                          i_ready;
  logic [DATA_WIDTH-1:0]         o_data;
  logic [SRC_W-1:0]              o_src;
  logic                          o_lock_err;

  modport slave (
    input  i_valid, i_data, i_lock, i_ready,
    output o_ready, o_valid, o_data, o_src, o_lock_err
  );

  modport master (
    output i_valid, i_data, i_lock, i_ready,
    input  o_ready, o_valid, o_data, o_src, o_lock_err
  );

endinterface

// File: rtl/cache_req_arb_rr_pick.sv
// Combinational round-robin select: first eligible index after ptr, wrapping.
module rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     elig,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Two ordered passes avoid a modulo on a non-power-of-2 N.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!found && elig[j] && (j > int'(ptr))) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IDX_W'(j);
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!found && elig[j] && (j <= int'(ptr))) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/cache_req_arb.sv
// N-way round-robin request arbiter with 1-entry input buffers, a registered
// output stage and bounded multi-beat channel locking.
module cache_req_arb
  import cache_arb_pkg::*;
#(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int DATA_WIDTH     = 5,
  parameter int MAX_LOCK_BEATS = DEF_MAX_LOCK_BEATS
) (
  input  logic           clk,
  input  logic           rst,
  cache_req_arb_if.slave bus
);
  localparam int SRC_W = src_idx_w(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_LOCK_BEATS + 1);

  logic [NUM_REQ-1:0]    buf_v;
  logic [NUM_REQ-1:0]    buf_lock;
  logic [NUM_REQ-1:0]    elig;
  logic [NUM_REQ-1:0]    grant;
  logic [DATA_WIDTH-1:0] buf_data [NUM_REQ];

  logic [SRC_W-1:0]      pick_idx;
  logic                  pick_found;
  logic                  pick_lock;
  logic                  load;
  logic                  do_load;

  arb_state_e            state_reg, state_next;
  logic [SRC_W-1:0]      owner_reg, owner_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic                  lock_err_reg, lock_err_next;
  logic [SRC_W-1:0]      ptr_reg;

  logic                  o_valid_reg;
  logic [DATA_WIDTH-1:0] o_data_reg;
  logic [SRC_W-1:0]      o_src_reg;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_buf
      logic                  v_reg;
      logic                  l_reg;
      logic [DATA_WIDTH-1:0] d_reg;

      // Clearing on the grant edge wins, so a slot never refills while draining.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v_reg <= 1'b0;
          l_reg <= 1'b0;
          d_reg <= '0;
        end else if (do_load && grant[gi]) begin
          v_reg <= 1'b0;
        end else if (bus.i_valid[gi] && !v_reg) begin
          v_reg <= 1'b1;
          l_reg <= bus.i_lock[gi];
          d_reg <= bus.i_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
      end

      assign buf_v[gi]    = v_reg;
      assign buf_lock[gi] = l_reg;
      assign buf_data[gi] = d_reg;
      assign elig[gi]     = v_reg && ((state_reg == ARB) || (owner_reg == SRC_W'(gi)));
    end
  endgenerate

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (SRC_W)
  ) u_pick (
    .elig  (elig),
    .ptr   (ptr_reg),
    .grant (grant),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign load      = !o_valid_reg || bus.i_ready;
  assign do_load   = load && pick_found;
  assign pick_lock = buf_lock[pick_idx];

  // A pending beat is replaced in place when it is accepted and a new one loads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid_reg <= 1'b0;
      o_data_reg  <= '0;
      o_src_reg   <= '0;
      ptr_reg     <= SRC_W'(NUM_REQ - 1);
    end else if (do_load) begin
      o_valid_reg <= 1'b1;
      o_data_reg  <= buf_data[pick_idx];
      o_src_reg   <= pick_idx;
      ptr_reg     <= pick_idx;
    end else if (bus.i_ready) begin
      o_valid_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ARB;
      owner_reg    <= '0;
      cnt_reg      <= '0;
      lock_err_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      owner_reg    <= owner_next;
      cnt_reg      <= cnt_next;
      lock_err_reg <= lock_err_next;
    end
  end

  // The beat that hits the limit is still delivered; only the lock is dropped.
  always_comb begin
    state_next    = state_reg;
    owner_next    = owner_reg;
    cnt_next      = cnt_reg;
    lock_err_next = 1'b0;
    if (do_load) begin
      unique case (state_reg)
        ARB: begin
          if (pick_lock) begin
            state_next = LOCKED;
            owner_next = pick_idx;
            cnt_next   = CNT_W'(1);
          end
        end
        LOCKED: begin
          if (!pick_lock) begin
            state_next = ARB;
            cnt_next   = '0;
          end else if (cnt_reg + CNT_W'(1) == CNT_W'(MAX_LOCK_BEATS)) begin
            state_next    = ARB;
            cnt_next      = '0;
            lock_err_next = 1'b1;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign bus.o_ready    = ~buf_v;
  assign bus.o_valid    = o_valid_reg;
  assign bus.o_data     = o_data_reg;
  assign bus.o_src      = o_src_reg;
  assign bus.o_lock_err = lock_err_reg;

endmodule

// File: tb/tb_cache_req_arb.sv
// Directed bench for cache_req_arb (2 requesters, MAX_LOCK_BEATS = 4).
module tb_cache_req_arb;

  logic clk;
  logic rst;

  cache_req_arb_if #(.NUM_REQ(2), .DATA_WIDTH(5)) bus ();

  cache_req_arb #(
    .NUM_REQ        (2),
    .DATA_WIDTH     (5),
    .MAX_LOCK_BEATS (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Pending beats per requester, entry = {lock, data[4:0]}.
  logic [5:0] q0[$];
  logic [5:0] q1[$];
  // Accepted output beats, entry = {src, data[4:0]}.
  logic [5:0] beat_log[$];
  int         err_cnt;
  logic [4:0] err_data;

  task automatic drive();
    logic [5:0] d0;
    logic [5:0] d1;
    d0 = 6'h0;
    d1 = 6'h0;
    if (q0.size() != 0) d0 = q0[0];
    if (q1.size() != 0) d1 = q1[0];
    bus.i_valid = {q1.size() != 0, q0.size() != 0};
    bus.i_data  = {d1[4:0], d0[4:0]};
    bus.i_lock  = {d1[5], d0[5]};
  endtask

  // Advance one clock; record handshakes seen before the edge.
  task automatic step();
    logic [1:0] hs;
    hs = bus.i_valid & bus.o_ready;
    if (bus.o_valid && bus.i_ready) beat_log.push_back({bus.o_src, bus.o_data});
    if (bus.o_lock_err) begin
      err_cnt++;
      err_data = bus.o_data;
    end
    @(posedge clk);
    #1;
    if (hs[0]) void'(q0.pop_front());
    if (hs[1]) void'(q1.pop_front());
    drive();
  endtask

  task automatic do_reset();
    q0.delete();
    q1.delete();
    drive();
    bus.i_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    beat_log.delete();
    err_cnt = 0;
  endtask

  task automatic test_reset();
    q0.delete();
    q1.delete();
    drive();
    bus.i_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.o_ready !== 2'b11) begin failures++; $display("FAIL reset_o_ready: got %b expected 11", bus.o_ready); end
    checks++;
    if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL reset_o_valid: got %b expected 0", bus.o_valid); end
    checks++;
    if (bus.o_data !== 5'h00 || bus.o_src !== 1'b0) begin failures++; $display("FAIL reset_out_regs: got data=%h src=%b expected 00/0", bus.o_data, bus.o_src); end
    checks++;
    if (bus.o_lock_err !== 1'b0) begin failures++; $display("FAIL reset_lock_err: got %b expected 0", bus.o_lock_err); end
    rst = 1'b0;
    step();
    checks++;
    if (bus.o_valid !== 1'b0 || bus.o_ready !== 2'b11) begin failures++; $display("FAIL reset_idle: got valid=%b ready=%b expected 0/11", bus.o_valid, bus.o_ready); end
    $display("test_reset done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_single();
    do_reset();
    q0.push_back(6'h0A);
    q0.push_back(6'h0B);
    drive();
    checks++;
    if (bus.o_ready[0] !== 1'b1) begin failures++; $display("FAIL single_c0_ready: got %b expected 1", bus.o_ready[0]); end
    step();
    checks++;
    if (bus.o_ready[0] !== 1'b0 || bus.o_valid !== 1'b0) begin failures++; $display("FAIL single_c1: got ready0=%b valid=%b expected 0/0", bus.o_ready[0], bus.o_valid); end
    step();
    checks++;
    if (bus.o_valid !== 1'b1 || bus.o_data !== 5'h0A || bus.o_src !== 1'b0) begin failures++; $display("FAIL single_c2_beat: got v=%b d=%h s=%b expected 1/0A/0", bus.o_valid, bus.o_data, bus.o_src); end
    step();
    checks++;
    if (bus.o_ready[0] !== 1'b0 || bus.o_valid !== 1'b0) begin failures++; $display("FAIL single_c3: got ready0=%b valid=%b expected 0/0", bus.o_ready[0], bus.o_valid); end
    step();
    checks++;
    if (bus.o_valid !== 1'b1 || bus.o_data !== 5'h0B || bus.o_src !== 1'b0) begin failures++; $display("FAIL single_c4_beat: got v=%b d=%h s=%b expected 1/0B/0", bus.o_valid, bus.o_data, bus.o_src); end
    step();
    checks++;
    if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL single_c5_idle: got %b expected 0", bus.o_valid); end
    $display("test_single done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_fairness();
    logic [4:0] exp_d;
    logic       exp_s;
    do_reset();
    for (int n = 0; n < 8; n++) begin
      q0.push_back(6'(n));
      q1.push_back(6'(16 + n));
    end
    drive();
    step();
    step();
    for (int b = 0; b < 8; b++) begin
      exp_s = b[0];
      exp_d = (b[0] ? 5'h10 : 5'h00) + 5'(b / 2);
      checks++;
      if (bus.o_valid !== 1'b1 || bus.o_src !== exp_s || bus.o_data !== exp_d) begin
        failures++;
        $display("FAIL fair_beat%0d: got v=%b s=%b d=%h expected 1/%b/%h", b, bus.o_valid, bus.o_src, bus.o_data, exp_s, exp_d);
      end
      step();
    end
    $display("test_fairness done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_backpressure();
    logic [5:0] exp_log [4];
    exp_log = '{6'h03, 6'h33, 6'h04, 6'h34};
    do_reset();
    bus.i_ready = 1'b0;
    q0.push_back(6'h03);
    q0.push_back(6'h04);
    q1.push_back(6'h13);
    q1.push_back(6'h14);
    drive();
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.o_valid !== 1'b1 || bus.o_data !== 5'h03 || bus.o_src !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold%0d: got v=%b d=%h s=%b expected 1/03/0", i, bus.o_valid, bus.o_data, bus.o_src);
      end
      if (i >= 1) begin
        checks++;
        if (bus.o_ready !== 2'b00) begin failures++; $display("FAIL bp_full%0d: got ready=%b expected 00", i, bus.o_ready); end
      end
      step();
    end
    bus.i_ready = 1'b1;
    repeat (8) step();
    checks++;
    if (beat_log.size() != 4) begin failures++; $display("FAIL bp_count: got %0d beats expected 4", beat_log.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < beat_log.size()) begin
        checks++;
        if (beat_log[i] !== exp_log[i]) begin failures++; $display("FAIL bp_order%0d: got %h expected %h", i, beat_log[i], exp_log[i]); end
      end
    end
    $display("test_backpressure done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_lock();
    logic [5:0] exp_log [7];
    exp_log = '{6'h31, 6'h32, 6'h33, 6'h01, 6'h02, 6'h03, 6'h04};
    do_reset();
    q1.push_back(6'h31);
    q1.push_back(6'h32);
    q1.push_back(6'h13);
    drive();
    step();
    for (int n = 1; n <= 4; n++) q0.push_back(6'(n));
    drive();
    repeat (3) step();
    checks++;
    if (bus.o_valid !== 1'b1 || bus.o_src !== 1'b1 || bus.o_data !== 5'h12 || bus.o_ready[0] !== 1'b0) begin
      failures++;
      $display("FAIL lock_c4: got v=%b s=%b d=%h ready0=%b expected 1/1/12/0", bus.o_valid, bus.o_src, bus.o_data, bus.o_ready[0]);
    end
    repeat (16) step();
    checks++;
    if (beat_log.size() != 7) begin failures++; $display("FAIL lock_count: got %0d beats expected 7", beat_log.size()); end
    for (int i = 0; i < 7; i++) begin
      if (i < beat_log.size()) begin
        checks++;
        if (beat_log[i] !== exp_log[i]) begin failures++; $display("FAIL lock_order%0d: got %h expected %h", i, beat_log[i], exp_log[i]); end
      end
    end
    checks++;
    if (err_cnt != 0) begin failures++; $display("FAIL lock_no_err: got %0d pulses expected 0", err_cnt); end
    $display("test_lock done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_lock_overflow();
    logic [5:0] exp_log [7];
    exp_log = '{6'h01, 6'h02, 6'h03, 6'h04, 6'h3F, 6'h05, 6'h06};
    do_reset();
    for (int n = 1; n <= 6; n++) q0.push_back(6'h20 | 6'(n));
    q1.push_back(6'h1F);
    drive();
    repeat (20) step();
    checks++;
    if (beat_log.size() != 7) begin failures++; $display("FAIL ovf_count: got %0d beats expected 7", beat_log.size()); end
    for (int i = 0; i < 7; i++) begin
      if (i < beat_log.size()) begin
        checks++;
        if (beat_log[i] !== exp_log[i]) begin failures++; $display("FAIL ovf_order%0d: got %h expected %h", i, beat_log[i], exp_log[i]); end
      end
    end
    checks++;
    if (err_cnt != 1) begin failures++; $display("FAIL ovf_err_pulses: got %0d expected 1", err_cnt); end
    checks++;
    if (err_data !== 5'h04) begin failures++; $display("FAIL ovf_err_timing: got beat %h during pulse expected 04", err_data); end
    $display("test_lock_overflow done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_reset_mid_lock();
    do_reset();
    q0.push_back(6'h21);
    q0.push_back(6'h22);
    q0.push_back(6'h23);
    q1.push_back(6'h11);
    drive();
    repeat (3) step();
    checks++;
    if (bus.o_ready !== 2'b00) begin failures++; $display("FAIL rml_full: got ready=%b expected 00", bus.o_ready); end
    q0.delete();
    q1.delete();
    drive();
    rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.o_valid !== 1'b0 || bus.o_ready !== 2'b11 || bus.o_lock_err !== 1'b0) begin
        failures++;
        $display("FAIL rml_in_reset%0d: got v=%b ready=%b err=%b expected 0/11/0", i, bus.o_valid, bus.o_ready, bus.o_lock_err);
      end
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    beat_log.delete();
    q1.push_back(6'h15);
    drive();
    checks++;
    if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL rml_after_release: got v=%b expected 0", bus.o_valid); end
    step();
    step();
    checks++;
    if (bus.o_valid !== 1'b1 || bus.o_src !== 1'b1 || bus.o_data !== 5'h15) begin
      failures++;
      $display("FAIL rml_fresh_grant: got v=%b s=%b d=%h expected 1/1/15", bus.o_valid, bus.o_src, bus.o_data);
    end
    repeat (4) step();
    checks++;
    if (beat_log.size() != 1 || beat_log[0] !== 6'h35) begin
      failures++;
      $display("FAIL rml_log: got %0d beats first=%h expected 1 beat 35", beat_log.size(), (beat_log.size() != 0) ? beat_log[0] : 6'h00);
    end
    checks++;
    if (err_cnt != 0) begin failures++; $display("FAIL rml_no_err: got %0d pulses expected 0", err_cnt); end
    $display("test_reset_mid_lock done checks=%0d failures=%0d", checks, failures);
  endtask

  initial begin
    rst         = 1'b1;
    bus.i_ready = 1'b1;
    err_cnt     = 0;
    err_data    = 5'h00;
    drive();
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_lock();
    test_lock_overflow();
    test_reset_mid_lock();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
